// File: rtl/pkt_counter_pkg.sv
// rtl/pkt_counter_pkg.sv - shared types and helpers for the packet counter bank
//
// Purpose : channel state encoding, mode constants and the channel-select
//           width helper used by pkt_counter_bank and pkt_counter_channel.
// Ports   : none (package).

package pkt_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int calc_ch_w(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/pkt_counter_channel.sv
// rtl/pkt_counter_channel.sv - one independent packet counter channel
//
// Purpose : IDLE/RUN counter with its own terminal value and mode, start/stop
//           control and a registered terminal pulse.
// Ports   :
//   CLK, RESET   clock, synchronous active-high reset
//   i_enable     shared count tick
//   i_cfg_we     write strobe for this channel's max/mode
//   i_cfg_max    new terminal value
//   i_cfg_mode   new mode (MODE_WRAP / MODE_ONESHOT)
//   i_start      start / restart request
//   i_stop       stop request (wins over start and terminal)
//   o_count      current count (register)
//   o_busy       channel is in RUN (register decode)
//   o_pulse      registered terminal pulse
//   o_term       combinational terminal event, registered by the bank

module pkt_counter_channel
  import pkt_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int DEFAULT_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     i_enable,
  input  logic                     i_cfg_we,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_max,
  input  logic                     i_cfg_mode,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_busy,
  output logic                     o_pulse,
  output logic                     o_term
);

  localparam logic [COUNTER_WIDTH-1:0] LP_DEFAULT_MAX = COUNTER_WIDTH'(DEFAULT_MAX);

  ch_state_t                r_state;
  ch_state_t                w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic [COUNTER_WIDTH-1:0] r_max;
  logic                     r_mode;
  logic                     r_pulse;

  logic [COUNTER_WIDTH-1:0] w_count_nxt;
  logic                     w_at_max;
  logic                     w_term;

  // >= rather than == so a max lowered below the current count still
  // terminates on the next enabled tick instead of running past it.
  assign w_at_max = (r_count >= r_max);

  // State register; max/mode are sampled here too so a same-cycle config
  // write only takes effect after the terminal test has used the old values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_max   <= LP_DEFAULT_MAX;
      r_mode  <= MODE_WRAP;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pulse <= w_term;
      if (i_cfg_we) begin
        r_max  <= i_cfg_max;
        r_mode <= i_cfg_mode;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!i_start && i_enable && w_at_max && (r_mode == MODE_ONESHOT)) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Count and terminal-event logic. Priority: stop, then idle/start restart,
  // then the enabled tick.
  always_comb begin
    w_count_nxt = r_count;
    w_term      = 1'b0;
    if (i_stop || (r_state == ST_IDLE) || i_start) begin
      w_count_nxt = '0;
    end else if (i_enable) begin
      if (w_at_max) begin
        w_count_nxt = '0;
        w_term      = 1'b1;
      end else begin
        w_count_nxt = r_count + COUNTER_WIDTH'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_busy  = (r_state == ST_RUN);
  assign o_pulse = r_pulse;
  assign o_term  = w_term;

endmodule

// File: rtl/pkt_counter_bank.sv
// rtl/pkt_counter_bank.sv - multi-channel programmable packet counter bank
//
// Purpose : NUM_CH independent counters sharing one ENABLE tick, each with a
//           runtime terminal value and wrap/one-shot mode.
// Ports   :
//   CLK, RESET   clock, synchronous active-high reset
//   ENABLE       shared count tick
//   CFG_WE       configuration write strobe
//   CFG_CH       channel to configure (values >= NUM_CH ignored)
//   CFG_MAX      new terminal value
//   CFG_MODE     0 = wrap, 1 = one-shot
//   START, STOP  per-channel start/restart and stop requests
//   COUNT        channel i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   BUSY         per-channel RUN indication
//   PULSE        per-channel registered terminal pulse
//   ANY_PULSE    registered OR of all terminal events

module pkt_counter_bank
  import pkt_counter_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int DEFAULT_MAX   = 9,
  parameter int CH_W          = calc_ch_w(NUM_CH)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ENABLE,
  input  logic                            CFG_WE,
  input  logic [CH_W-1:0]                 CFG_CH,
  input  logic [COUNTER_WIDTH-1:0]        CFG_MAX,
  input  logic                            CFG_MODE,
  input  logic [NUM_CH-1:0]               START,
  input  logic [NUM_CH-1:0]               STOP,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] COUNT,
  output logic [NUM_CH-1:0]               BUSY,
  output logic [NUM_CH-1:0]               PULSE,
  output logic                            ANY_PULSE
);

  logic [NUM_CH-1:0] w_cfg_we;
  logic [NUM_CH-1:0] w_term;
  logic              r_any_pulse;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Only channels that exist get a decode, so out-of-range selects fall
    // through without touching any channel.
    assign w_cfg_we[g] = CFG_WE && (int'(CFG_CH) == g);

    pkt_counter_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .DEFAULT_MAX   (DEFAULT_MAX)
    ) u_channel (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_enable   (ENABLE),
      .i_cfg_we   (w_cfg_we[g]),
      .i_cfg_max  (CFG_MAX),
      .i_cfg_mode (CFG_MODE),
      .i_start    (START[g]),
      .i_stop     (STOP[g]),
      .o_count    (COUNT[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .o_busy     (BUSY[g]),
      .o_pulse    (PULSE[g]),
      .o_term     (w_term[g])
    );
  end

  // Registered from the same terminal events as PULSE, so it lines up with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_any_pulse <= 1'b0;
    end else begin
      r_any_pulse <= |w_term;
    end
  end

  assign ANY_PULSE = r_any_pulse;

endmodule
